// File: rtl/morph_3x3_1bit.sv
// Binary 3x3 morphology stage: bypass/erode/dilate/majority on a 1-bit window,
// forced border value, aligned de/vs and per-frame foreground pixel count.
module morph_3x3_1bit #(
    parameter int   IMG_WIDTH  = 1920,
    parameter int   IMG_HEIGHT = 1080,
    parameter logic BORDER_VAL = 1'b0,
    parameter int   VS_DLY     = 4
) (
    input  logic        video_clk,
    input  logic        rst_n,
    input  logic        video_vs,
    input  logic        matrix_de,
    input  logic        matrix11,
    input  logic        matrix12,
    input  logic        matrix13,
    input  logic        matrix21,
    input  logic        matrix22,
    input  logic        matrix23,
    input  logic        matrix31,
    input  logic        matrix32,
    input  logic        matrix33,
    input  logic [1:0]  mode_cfg,
    output logic        o_vs,
    output logic        o_de,
    output logic        o_data,
    output logic [21:0] fg_cnt,
    output logic        fg_valid
);

    localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT - 1);

    logic              vs_prev_q;
    logic [VS_DLY-1:0] vs_sr_q;
    logic [1:0]        mode_q;
    logic [11:0]       x_cnt_q, y_cnt_q;

    logic s1_erode_q, s1_dilate_q, s1_maj_q, s1_center_q;
    logic s1_border_q, s1_de_q, s1_last_q;
    logic o_de_q, o_data_q, s2_last_q;

    logic [21:0] acc_q, fg_cnt_q;
    logic        fg_valid_q;

    logic        vs_rise;
    logic [8:0]  win;
    logic [3:0]  pop_d;
    logic        border_d, last_d;
    logic        sel_d, pix_d;

    assign vs_rise = video_vs & ~vs_prev_q;
    assign win = {matrix11, matrix12, matrix13,
                  matrix21, matrix22, matrix23,
                  matrix31, matrix32, matrix33};

    always_comb begin
        pop_d = 4'd0;
        for (int i = 0; i < 9; i++) begin
            pop_d = pop_d + 4'(win[i]);
        end
    end

    assign border_d = matrix_de && (x_cnt_q == 12'd0 || x_cnt_q == X_LAST ||
                                    y_cnt_q == 12'd0 || y_cnt_q == Y_LAST);
    assign last_d   = matrix_de && (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);

    // vsync edge detect, mode capture and output vsync alignment
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            vs_sr_q   <= '0;
            mode_q    <= 2'd0;
        end else begin
            vs_prev_q <= video_vs;
            vs_sr_q   <= {vs_sr_q[VS_DLY-2:0], video_vs};
            if (vs_rise) begin
                mode_q <= mode_cfg;
            end
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_q <= 12'd0;
            y_cnt_q <= 12'd0;
        end else if (vs_rise) begin
            x_cnt_q <= 12'd0;
            y_cnt_q <= 12'd0;
        end else if (matrix_de) begin
            if (x_cnt_q == X_LAST) begin
                x_cnt_q <= 12'd0;
                y_cnt_q <= (y_cnt_q == Y_LAST) ? 12'd0 : y_cnt_q + 12'd1;
            end else begin
                x_cnt_q <= x_cnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_erode_q  <= 1'b0;
            s1_dilate_q <= 1'b0;
            s1_maj_q    <= 1'b0;
            s1_center_q <= 1'b0;
            s1_border_q <= 1'b0;
            s1_de_q     <= 1'b0;
            s1_last_q   <= 1'b0;
        end else begin
            s1_erode_q  <= &win;
            s1_dilate_q <= |win;
            s1_maj_q    <= (pop_d >= 4'd5);
            s1_center_q <= matrix22;
            s1_border_q <= border_d;
            s1_de_q     <= matrix_de;
            s1_last_q   <= last_d;
        end
    end

    always_comb begin
        sel_d = s1_center_q;
        unique case (mode_q)
            2'd0: sel_d = s1_center_q;
            2'd1: sel_d = s1_erode_q;
            2'd2: sel_d = s1_dilate_q;
            2'd3: sel_d = s1_maj_q;
            default: sel_d = s1_center_q;
        endcase
    end

    // border override applies to every mode except bypass; idle cycles output zero
    assign pix_d = s1_de_q ? ((s1_border_q && mode_q != 2'd0) ? BORDER_VAL : sel_d) : 1'b0;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_de_q    <= 1'b0;
            o_data_q  <= 1'b0;
            s2_last_q <= 1'b0;
        end else begin
            o_de_q    <= s1_de_q;
            o_data_q  <= pix_d;
            s2_last_q <= s1_de_q & s1_last_q;
        end
    end

    // last-pixel publish wins over a coincident vsync rise; both clear the accumulator
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= 22'd0;
            fg_cnt_q   <= 22'd0;
            fg_valid_q <= 1'b0;
        end else begin
            fg_valid_q <= 1'b0;
            if (s2_last_q) begin
                fg_cnt_q   <= acc_q + {21'd0, o_data_q};
                fg_valid_q <= 1'b1;
                acc_q      <= 22'd0;
            end else if (vs_rise) begin
                acc_q <= 22'd0;
            end else if (o_de_q && o_data_q) begin
                acc_q <= acc_q + 22'd1;
            end
        end
    end

    assign o_vs     = vs_sr_q[VS_DLY-1];
    assign o_de     = o_de_q;
    assign o_data   = o_data_q;
    assign fg_cnt   = fg_cnt_q;
    assign fg_valid = fg_valid_q;

endmodule

// File: tb/tb_morph_3x3_1bit.sv
// Scoreboard bench for morph_3x3_1bit on an 8x6 frame: pixel values, latency,
// vsync alignment, foreground count pulses, mode capture and reset behaviour.
module tb_morph_3x3_1bit;

    localparam int   W  = 8;
    localparam int   H  = 6;
    localparam logic BV = 1'b0;

    logic        video_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        video_vs  = 1'b0;
    logic        matrix_de = 1'b0;
    logic [8:0]  win       = 9'd0;
    logic [1:0]  mode_cfg  = 2'd0;
    logic        o_vs, o_de, o_data, fg_valid;
    logic [21:0] fg_cnt;

    always #5 video_clk = ~video_clk;

    morph_3x3_1bit #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER_VAL(BV), .VS_DLY(4)) dut (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .video_vs  (video_vs),
        .matrix_de (matrix_de),
        .matrix11  (win[8]),
        .matrix12  (win[7]),
        .matrix13  (win[6]),
        .matrix21  (win[5]),
        .matrix22  (win[4]),
        .matrix23  (win[3]),
        .matrix31  (win[2]),
        .matrix32  (win[1]),
        .matrix33  (win[0]),
        .mode_cfg  (mode_cfg),
        .o_vs      (o_vs),
        .o_de      (o_de),
        .o_data    (o_data),
        .fg_cnt    (fg_cnt),
        .fg_valid  (fg_valid)
    );

    typedef struct {
        logic d;
        int   cyc;
    } pix_t;

    pix_t       pq[$];
    int         fq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         tx = 0, ty = 0, fg_acc = 0;
    logic [1:0] tmode = 2'd0;
    logic [4:0] vs_hist = 5'd0;
    logic [8:0] pats [6];

    always @(posedge video_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge video_clk) begin
        if (!rst_n) begin
            vs_hist = 5'd0;
        end else begin
            check("o_vs_delay", o_vs, vs_hist[3]);
            vs_hist = {vs_hist[3:0], video_vs};
            if (o_de) begin
                if (pq.size() == 0) begin
                    check("de_with_empty_queue", o_de, 0);
                end else begin
                    pix_t p;
                    p = pq.pop_front();
                    check("o_data", o_data, p.d);
                    check("latency", cyc - p.cyc, 2);
                end
            end else begin
                check("idle_data_zero", o_data, 0);
            end
            if (fg_valid) begin
                if (fq.size() == 0) check("fg_pulse_unexpected", fg_valid, 0);
                else                check("fg_cnt", fg_cnt, fq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic gap(input int n);
        matrix_de = 1'b0;
        video_vs  = 1'b0;
        repeat (n) begin
            win = 9'($urandom_range(0, 511));
            tick();
        end
    endtask

    task automatic vs_start(input logic [1:0] m);
        mode_cfg  = m;
        matrix_de = 1'b0;
        video_vs  = 1'b1;
        tick();
        tick();
        video_vs = 1'b0;
        tick();
        tmode  = m;
        tx     = 0;
        ty     = 0;
        fg_acc = 0;
    endtask

    task automatic pix(input logic [8:0] w);
        logic e, brd;
        matrix_de = 1'b1;
        video_vs  = 1'b0;
        win       = w;
        brd = (tx == 0) || (tx == W - 1) || (ty == 0) || (ty == H - 1);
        case (tmode)
            2'd0:    e = w[4];
            2'd1:    e = &w;
            2'd2:    e = |w;
            default: e = ($countones(w) >= 5);
        endcase
        if (brd && tmode != 2'd0) e = BV;
        pq.push_back('{e, cyc});
        if (e) fg_acc++;
        if (tx == W - 1 && ty == H - 1) begin
            fq.push_back(fg_acc);
            fg_acc = 0;
        end
        if (tx == W - 1) begin
            tx = 0;
            ty = (ty == H - 1) ? 0 : ty + 1;
        end else begin
            tx++;
        end
        tick();
    endtask

    // kind 0: all ones, 1: random, 2: directed corner-case windows
    task automatic frame(input int kind, input int npix);
        for (int i = 0; i < npix; i++) begin
            logic [8:0] w;
            case (kind)
                0:       w = 9'h1FF;
                1:       w = 9'($urandom_range(0, 511));
                default: w = pats[i % 6];
            endcase
            pix(w);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        end
    endtask

    initial begin
        pats[0] = 9'b001000000;
        pats[1] = 9'b000000000;
        pats[2] = 9'b110100100;
        pats[3] = 9'b110110100;
        pats[4] = 9'b000010000;
        pats[5] = 9'b111101111;

        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_o_de", o_de, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_vs", o_vs, 0);
        check("rst_fg_valid", fg_valid, 0);
        check("rst_fg_cnt", fg_cnt, 0);
        rst_n = 1'b1;
        gap(3);

        vs_start(2'd0); frame(0, W * H); gap(5);
        vs_start(2'd1); frame(0, W * H); gap(5);
        vs_start(2'd2); frame(2, W * H); gap(5);
        vs_start(2'd3); frame(2, W * H); gap(5);
        vs_start(2'd3); frame(1, W * H); gap(5);
        vs_start(2'd0); frame(2, W * H); gap(5);

        // mode_cfg changes mid-frame; erode must hold until the next vsync rise
        vs_start(2'd1); frame(1, W * H / 2);
        mode_cfg = 2'd2;
        frame(1, W * H / 2); gap(5);
        vs_start(2'd2); frame(1, W * H); gap(5);

        // truncated frame: no count pulse, accumulator restarts
        vs_start(2'd0); frame(0, 20); gap(2);
        vs_start(2'd0); frame(0, W * H); gap(5);

        // reset mid-stream
        vs_start(2'd2); frame(0, 10);
        rst_n     = 1'b0;
        matrix_de = 1'b0;
        #1;
        check("midrst_o_de", o_de, 0);
        check("midrst_o_data", o_data, 0);
        check("midrst_o_vs", o_vs, 0);
        check("midrst_fg_valid", fg_valid, 0);
        check("midrst_fg_cnt", fg_cnt, 0);
        pq.delete();
        fq.delete();
        tick();
        tick();
        rst_n = 1'b1;
        gap(3);
        vs_start(2'd1); frame(0, W * H); gap(10);

        check("pix_queue_drained", pq.size(), 0);
        check("fg_queue_drained", fq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
